approx_err_monitor: RTL and testbench
=====================================

# approx_err_monitor

Sequential error-statistics collector that sits directly downstream of the 8x8 approximate multiplier. For each accepted operand pair (a, b), it takes the multiplier's product r_approx and computes the exact product a*b internally. It accumulates the error distance ED = |a*b - r_approx| over a programmed number of samples. It reports the error count, saturating ED sum, maximum ED and the operands that produced it. This is the on-chip characterisation stage for the approximate-multiplier configurations.

## Interface

- CNT_W, 16, width of sample counter, num_samples and err_cnt
- SUM_W, 32, width of ED accumulator sum_ed; legal range 17..48
- clk  in  1  single clock; all logic rising-edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begins a run when sampled high in IDLE; ignored in any other state
- num_samples  in  CNT_W  sample count for the run, latched on the start edge
- in_valid  in  1  operand/product triple valid
- in_ready  out  1  block accepts triple this cycle
- a  in  8  multiplicand (unsigned)
- b  in  8  multiplier (unsigned)
- r_approx  in  16  approximate product of this same a, b, combinational from the multiplier
- busy  out  1  high in RUN, DRAIN, DONE
- done  out  1  one-cycle pulse; statistics final
- err_cnt  out  CNT_W  number of samples with ED != 0
- sum_ed  out  SUM_W  sum of ED, saturating at all-ones
- sum_sat  out  1  sticky; set when sum_ed saturated
- max_ed  out  16  largest ED seen in the run
- worst_a  out  8  a of the first sample reaching max_ed
- worst_b  out  8  b of the first sample reaching max_ed

## Operation

- FSM: IDLE, RUN, DRAIN, DONE.
  - IDLE & start: latch num_samples, clear all statistics and sum_sat, reset accepted count.
    - Go to RUN if num_samples != 0; otherwise go to DRAIN.
  - RUN: in_ready = 1. A transfer occurs on in_valid & in_ready.
    - On the transfer that makes the accepted count equal num_samples, go to DRAIN.
  - DRAIN: in_ready = 0. When both pipeline valids (v1, v2) are low, go to DONE.
  - DONE: done = 1 for exactly one cycle, then go to IDLE.
- in_ready is 0 in IDLE, DRAIN and DONE. No skid or backpressure on the output side.
- Pipeline:
  - Stage 1, on transfer: register a, b, r_approx, exact = a*b (16-bit unsigned), v1.
  - Stage 2: ED = |exact - r_approx|, computed as a 17-bit signed difference then absolute value, which fits in 16 bits. Register ED, a, b, v2.
  - Stage 3, when v2 is high:
    - err_cnt += (ED != 0).
    - sum_ed += ED. If the true sum exceeds 2^SUM_W-1, hold sum_ed at all-ones and set sum_sat.
    - If ED > max_ed (strictly greater), update max_ed, worst_a and worst_b. Ties keep the earlier sample.
- err_cnt cannot overflow, since it is bounded by num_samples.
- Statistics hold their values from DONE until the next accepted start.
- Reset values: all outputs 0, state IDLE, v1 = v2 = 0.
- Reset mid-run aborts the run, flushes the pipeline and clears all statistics. done is not pulsed.

## Timing

- Latency from a transfer at edge t: stage 1 loads at t, ED registers at t+1, statistics updated at t+2. The result is visible in the cycle after t+2.
- Throughput: one sample per cycle while in_valid is held high.
- Last transfer at edge t (state enters DRAIN at t): DONE is entered at t+3, and done is high in the cycle after t+3. Statistics are already final in that cycle. IDLE is entered at t+4.
- num_samples = 0: start at edge s gives DRAIN at s, DONE at s+1, IDLE at s+2. All statistics are 0.
- start asserted in the DONE cycle is ignored. start is accepted in IDLE from t+4 onward.
- in_valid during IDLE or DRAIN: no transfer and no effect.

## Test plan

- Run 1, num_samples = 1, a = 3, b = 5, r_approx = 15:
  - done pulses exactly 3 cycles after the transfer edge.
  - err_cnt = 0, sum_ed = 0, max_ed = 0.
- Run 2, num_samples = 3, back-to-back triples (255, 255, 64000), (2, 3, 10), (255, 255, 64000):
  - ED values are 1025, 4, 1025.
  - err_cnt = 3, sum_ed = 2054, max_ed = 1025, worst_a = worst_b = 255, recorded from the first sample.
- Gapped valid, num_samples = 4 with in_valid toggling every other cycle:
  - Exactly 4 transfers occur.
  - in_ready drops on the edge of the 4th transfer.
  - Extra in_valid pulses afterwards do not change the statistics.
- num_samples = 0:
  - done pulses 1 cycle after the start edge, with all statistics 0.
  - busy is high for 2 cycles.
- Saturation, with SUM_W = 17 and 3 samples of ED = 65535 (a = 255, b = 255, r_approx = 0... substitute exact 65025 so ED = 65025 each):
  - sum_ed = 131071 and sum_sat = 1.
  - sum_sat stays set until the next start.
- Reset mid-run: assert rst for 1 cycle after the 2nd of 5 transfers.
  - All outputs return to 0 and state is IDLE.
  - done never pulses.
  - A new run afterwards produces correct statistics.

Source files
------------

// File: rtl/approx_err_monitor.sv
// Error-statistics collector for the 8x8 approximate multiplier: compares each accepted
// product against the exact a*b and accumulates count, saturating sum and maximum of |ED|.
module approx_err_monitor #(
  parameter int CNT_W = 16,
  parameter int SUM_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  input  logic [15:0]      r_approx,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_cnt,
  output logic [SUM_W-1:0] sum_ed,
  output logic             sum_sat,
  output logic [15:0]      max_ed,
  output logic [7:0]       worst_a,
  output logic [7:0]       worst_b
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] num_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  logic        v1;
  logic [7:0]  s1_a;
  logic [7:0]  s1_b;
  logic [15:0] s1_r;
  logic [15:0] s1_exact;

  logic        v2;
  logic [7:0]  s2_a;
  logic [7:0]  s2_b;
  logic [15:0] s2_ed;

  logic             xfer;
  logic [16:0]      diff;
  logic [16:0]      diff_abs;
  logic [SUM_W:0]   sum_wide;

  assign in_ready = (state == RUN);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  assign xfer     = in_valid & (state == RUN);
  assign cnt_next = cnt_reg + 1'b1;

  // 17-bit signed difference; its magnitude always fits in 16 bits
  assign diff     = {1'b0, s1_exact} - {1'b0, s1_r};
  assign diff_abs = diff[16] ? (~diff + 17'd1) : diff;
  assign sum_wide = {1'b0, sum_ed} + {{(SUM_W - 15){1'b0}}, s2_ed};

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      num_reg  <= '0;
      cnt_reg  <= '0;
      v1       <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_r     <= '0;
      s1_exact <= '0;
      v2       <= 1'b0;
      s2_a     <= '0;
      s2_b     <= '0;
      s2_ed    <= '0;
      err_cnt  <= '0;
      sum_ed   <= '0;
      sum_sat  <= 1'b0;
      max_ed   <= '0;
      worst_a  <= '0;
      worst_b  <= '0;
    end else begin
      v1 <= xfer;
      if (xfer) begin
        s1_a     <= a;
        s1_b     <= b;
        s1_r     <= r_approx;
        s1_exact <= a * b;
      end

      v2 <= v1;
      if (v1) begin
        s2_a  <= s1_a;
        s2_b  <= s1_b;
        s2_ed <= diff_abs[15:0];
      end

      if (v2) begin
        err_cnt <= err_cnt + CNT_W'(s2_ed != 16'd0);
        if (sum_wide[SUM_W]) begin
          sum_ed  <= '1;
          sum_sat <= 1'b1;
        end else begin
          sum_ed <= sum_wide[SUM_W-1:0];
        end
        // strict compare keeps the earliest sample on ties
        if (s2_ed > max_ed) begin
          max_ed  <= s2_ed;
          worst_a <= s2_a;
          worst_b <= s2_b;
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            num_reg <= num_samples;
            cnt_reg <= '0;
            err_cnt <= '0;
            sum_ed  <= '0;
            sum_sat <= 1'b0;
            max_ed  <= '0;
            worst_a <= '0;
            worst_b <= '0;
            state   <= (num_samples != '0) ? RUN : DRAIN;
          end
        end
        RUN: begin
          if (xfer) begin
            cnt_reg <= cnt_next;
            if (cnt_next == num_reg) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!v1 && !v2) state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_approx_err_monitor.sv
// Bench for approx_err_monitor: directed table runs, hand-written corner sequences and
// randomized runs checked against a plain-arithmetic error-statistics model.
module tb_approx_err_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] num_samples;
  logic        in_valid;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [15:0] r_approx;

  logic        in_ready, busy, done, sum_sat;
  logic [15:0] err_cnt, max_ed;
  logic [31:0] sum_ed;
  logic [7:0]  worst_a, worst_b;

  logic        s_in_ready, s_busy, s_done, s_sum_sat;
  logic [15:0] s_err_cnt, s_max_ed;
  logic [16:0] s_sum_ed;
  logic [7:0]  s_worst_a, s_worst_b;

  approx_err_monitor #(.CNT_W(16), .SUM_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .r_approx(r_approx),
    .busy(busy), .done(done), .err_cnt(err_cnt), .sum_ed(sum_ed), .sum_sat(sum_sat),
    .max_ed(max_ed), .worst_a(worst_a), .worst_b(worst_b)
  );

  approx_err_monitor #(.CNT_W(16), .SUM_W(17)) dut_s (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(s_in_ready), .a(a), .b(b), .r_approx(r_approx),
    .busy(s_busy), .done(s_done), .err_cnt(s_err_cnt), .sum_ed(s_sum_ed), .sum_sat(s_sum_sat),
    .max_ed(s_max_ed), .worst_a(s_worst_a), .worst_b(s_worst_b)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int qa[32];
  int qb[32];
  int qr[32];

  typedef struct {
    int     n;
    int     gap;
    int     ta[3];
    int     tb[3];
    int     tr[3];
    int     e_err;
    longint e_s32;
    longint e_s17;
    bit     e_sat17;
    int     e_max;
    int     e_wa;
    int     e_wb;
    int     e_lat;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: error statistics of the accepted triples, from first principles
  task automatic model(input int n, output int e_err, output longint e_s32, output longint e_s17,
                       output bit e_sat17, output int e_max, output int e_wa, output int e_wb);
    longint tot;
    tot = 0; e_err = 0; e_max = 0; e_wa = 0; e_wb = 0;
    for (int i = 0; i < n; i++) begin
      int ed;
      ed = qa[i] * qb[i] - qr[i];
      if (ed < 0) ed = -ed;
      if (ed != 0) e_err++;
      tot += ed;
      if (ed > e_max) begin
        e_max = ed; e_wa = qa[i]; e_wb = qb[i];
      end
    end
    e_s32   = (tot > 64'd4294967295) ? 64'd4294967295 : tot;
    e_s17   = (tot > 131071) ? 131071 : tot;
    e_sat17 = (tot > 131071);
  endtask

  task automatic run(input int n, input int gap, input int e_err, input longint e_s32,
                     input longint e_s17, input bit e_sat17, input int e_max, input int e_wa,
                     input int e_wb, input int e_lat);
    int idx, cyc, lat;
    bit x;
    idx = 0; cyc = 0; lat = 0;
    @(negedge clk);
    start = 1'b1; num_samples = n[15:0]; in_valid = 1'b0;
    @(posedge clk); #1;
    chk("busy_after_start", busy, 1);
    while (idx < n && cyc < 2000) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (gap == 0)      in_valid = 1'b1;
      else if (gap == 1) in_valid = (cyc % 2 == 1);
      else               in_valid = ($urandom % 3 != 0);
      if (in_valid) begin
        a = qa[idx][7:0]; b = qb[idx][7:0]; r_approx = qr[idx][15:0];
      end else begin
        a = 8'($urandom); b = 8'($urandom); r_approx = 16'($urandom);
      end
      x = in_valid && in_ready;
      @(posedge clk); #1;
      if (x) begin
        idx++;
        chk("in_ready_after_xfer", in_ready, (idx < n) ? 1 : 0);
      end
    end
    if (idx < n) chk("xfer_timeout", idx, n);
    while (lat < 50) begin
      @(negedge clk);
      start = 1'b0;
      in_valid = 1'(($urandom % 2));
      a = 8'($urandom); b = 8'($urandom); r_approx = 16'($urandom);
      @(posedge clk);
      lat++;
      #1;
      if (done) break;
    end
    chk("done_latency", lat, e_lat);
    chk("busy_in_done", busy, 1);
    chk("err_cnt", err_cnt, e_err);
    chk("sum_ed32", sum_ed, e_s32);
    chk("sum_sat32", sum_sat, (e_s32 == 64'd4294967295) ? 1 : 0);
    chk("sum_ed17", s_sum_ed, e_s17);
    chk("sum_sat17", s_sum_sat, e_sat17);
    chk("max_ed", max_ed, e_max);
    chk("worst_a", worst_a, e_wa);
    chk("worst_b", worst_b, e_wb);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
    chk("busy_back_idle", busy, 0);
    chk("err_cnt_hold", err_cnt, e_err);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_err_cnt"}, err_cnt, 0);
    chk({tag, "_sum_ed"}, sum_ed, 0);
    chk({tag, "_sum_ed17"}, s_sum_ed, 0);
    chk({tag, "_sum_sat"}, sum_sat, 0);
    chk({tag, "_max_ed"}, max_ed, 0);
    chk({tag, "_worst_ab"}, {worst_a, worst_b}, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
  endtask

  initial begin
    int e_err, e_max, e_wa, e_wb, n, md, v, dn;
    longint e_s32, e_s17;
    bit e_sat17;

    tbl[0] = '{1, 0, '{3, 0, 0}, '{5, 0, 0}, '{15, 0, 0}, 0, 0, 0, 1'b0, 0, 0, 0, 3};
    tbl[1] = '{3, 0, '{255, 2, 255}, '{255, 3, 255}, '{64000, 10, 64000},
               3, 2054, 2054, 1'b0, 1025, 255, 255, 3};
    tbl[2] = '{0, 0, '{0, 0, 0}, '{0, 0, 0}, '{0, 0, 0}, 0, 0, 0, 1'b0, 0, 0, 0, 1};
    tbl[3] = '{3, 0, '{255, 255, 255}, '{255, 255, 255}, '{0, 0, 0},
               3, 195075, 131071, 1'b1, 65025, 255, 255, 3};

    rst = 1'b1; start = 1'b0; num_samples = '0; in_valid = 1'b0;
    a = '0; b = '0; r_approx = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 3; i++) begin
        qa[i] = tbl[t].ta[i]; qb[i] = tbl[t].tb[i]; qr[i] = tbl[t].tr[i];
      end
      run(tbl[t].n, tbl[t].gap, tbl[t].e_err, tbl[t].e_s32, tbl[t].e_s17, tbl[t].e_sat17,
          tbl[t].e_max, tbl[t].e_wa, tbl[t].e_wb, tbl[t].e_lat);
      $display("table run %0d n=%0d err=%0d sum=%0d max=%0d", t, tbl[t].n, err_cnt, sum_ed, max_ed);
    end

    // saturation flag stays sticky while idle
    repeat (3) @(posedge clk);
    #1;
    chk("sat_sticky", s_sum_sat, 1);
    chk("sat_sum_hold", s_sum_ed, 131071);

    // gapped valid, four samples
    for (int i = 0; i < 4; i++) begin
      qa[i] = int'($urandom_range(0, 255)); qb[i] = int'($urandom_range(0, 255));
      qr[i] = int'($urandom_range(0, 65535));
    end
    model(4, e_err, e_s32, e_s17, e_sat17, e_max, e_wa, e_wb);
    run(4, 1, e_err, e_s32, e_s17, e_sat17, e_max, e_wa, e_wb, 3);
    $display("gapped run n=4 err=%0d sum=%0d max=%0d", err_cnt, sum_ed, max_ed);

    // start raised during the DONE cycle is ignored
    @(negedge clk);
    start = 1'b1; num_samples = 16'd0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    chk("zero_run_done", done, 1);
    @(negedge clk);
    start = 1'b1; num_samples = 16'd2;
    @(posedge clk); #1;
    chk("start_in_done_ignored", busy, 0);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    chk("still_idle", busy, 0);
    $display("start-in-DONE sequence busy=%0d", busy);

    // reset after the second of five transfers
    for (int i = 0; i < 5; i++) begin
      qa[i] = 200 + i; qb[i] = 100; qr[i] = 0;
    end
    @(negedge clk);
    start = 1'b1; num_samples = 16'd5;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      start = 1'b0; in_valid = 1'b1;
      a = qa[i][7:0]; b = qb[i][7:0]; r_approx = qr[i][15:0];
      @(posedge clk);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    check_all_zero("midrst");
    dn = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
    chk("no_done_after_rst", dn, 0);
    $display("mid-run reset sequence done_pulses=%0d", dn);

    // randomized runs
    for (int r = 0; r < 12; r++) begin
      n = int'($urandom_range(1, 20));
      for (int i = 0; i < n; i++) begin
        qa[i] = int'($urandom_range(0, 255));
        qb[i] = int'($urandom_range(0, 255));
        md = int'($urandom_range(0, 3));
        if (md == 0) v = qa[i] * qb[i];
        else if (md == 1) v = qa[i] * qb[i] + int'($urandom_range(0, 64)) - 32;
        else if (md == 2) v = int'($urandom_range(0, 65535));
        else begin
          qa[i] = 255; qb[i] = 255; v = int'($urandom_range(0, 300));
        end
        if (v < 0) v = 0;
        if (v > 65535) v = 65535;
        qr[i] = v;
      end
      model(n, e_err, e_s32, e_s17, e_sat17, e_max, e_wa, e_wb);
      run(n, int'($urandom_range(0, 2)), e_err, e_s32, e_s17, e_sat17, e_max, e_wa, e_wb, 3);
      $display("random run %0d n=%0d err=%0d sum=%0d max=%0d", r, n, err_cnt, sum_ed, max_ed);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
